// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, default
// frame parameters and the oversampling rate of the baud tick.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int DBIT_DEFAULT    = 8;
   localparam int SB_TICK_DEFAULT = 16;
   localparam int OVERSAMPLE      = 16;

   // Tick counter must reach SB_TICK-1, which needs a fifth bit for 1.5/2 stop bits.
   function automatic int tick_cnt_width(input int sb_tick);
      return (sb_tick > OVERSAMPLE) ? 5 : 4;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Bundle of the transmitter's request/data/status signals, seen from the
// side that feeds the transmitter (master) and from the transmitter (slave).
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int DBIT = DBIT_DEFAULT
);
   logic            s_tick;
   logic            tx_start;
   logic [DBIT-1:0] din;
   logic            tx;
   logic            busy;
   logic            tx_done_tick;

   modport master (
      output s_tick, tx_start, din,
      input  tx, busy, tx_done_tick
   );

   modport slave (
      input  s_tick, tx_start, din,
      output tx, busy, tx_done_tick
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK-tick stop
// level, paced by a 16x oversampling tick; serial output is registered.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEFAULT,
   parameter int SB_TICK = SB_TICK_DEFAULT
)(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_s_tick,
   input  logic            i_tx_start,
   input  logic [DBIT-1:0] i_din,
   output logic            o_tx,
   output logic            o_busy,
   output logic            o_tx_done_tick
);

   localparam int            SW          = tick_cnt_width(SB_TICK);
   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

   state_e          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [2:0]      n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            tx_q, tx_d;
   logic            done_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      done_d  = 1'b0;
      tx_d    = 1'b1;

      case (state_q)
         IDLE: begin
            if (i_tx_start) begin
               state_d = START;
               s_d     = '0;
               b_d     = i_din;
            end
         end
         START: begin
            if (i_s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  state_d = DATA;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (s_q == S_STOP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the next state so it switches on the same edge.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = b_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign o_tx           = tx_q;
   assign o_busy         = (state_q != IDLE);
   assign o_tx_done_tick = done_d;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance with 1 stop bit and one with 2, both fed the
// same stimulus and compared every cycle against a frame-position model.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_tick;
   logic       tx_start;
   logic [7:0] din;

   logic [1:0] tx_w, busy_w, done_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         uart_tx_if #(.DBIT(8)) ifc ();
         assign ifc.s_tick   = s_tick;
         assign ifc.tx_start = tx_start;
         assign ifc.din      = din;

         uart_tx #(.DBIT(8), .SB_TICK((gi == 0) ? 16 : 32)) dut (
            .i_clk          (clk),
            .i_reset        (rst),
            .i_s_tick       (ifc.s_tick),
            .i_tx_start     (ifc.tx_start),
            .i_din          (ifc.din),
            .o_tx           (ifc.tx),
            .o_busy         (ifc.busy),
            .o_tx_done_tick (ifc.tx_done_tick)
         );

         assign tx_w[gi]   = ifc.tx;
         assign busy_w[gi] = ifc.busy;
         assign done_w[gi] = ifc.tx_done_tick;
      end
   endgenerate

   // Reference: a frame is a list of tick slots; position in the frame decides the level.
   logic       m_act   [2];
   int         m_pos   [2];
   logic [7:0] m_frame [2];

   function automatic int frame_len(input int k);
      return 9 * 16 + ((k == 0) ? 16 : 32);
   endfunction

   function automatic logic exp_tx(input int k);
      int p;
      if (!m_act[k]) return 1'b1;
      p = m_pos[k];
      if (p < 16) return 1'b0;
      if (p < 144) return m_frame[k][(p - 16) / 16];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_act[k] <= 1'b0;
            m_pos[k] <= 0;
         end else if (!m_act[k]) begin
            if (tx_start) begin
               m_act[k]   <= 1'b1;
               m_pos[k]   <= 0;
               m_frame[k] <= din;
            end
         end else if (s_tick) begin
            if (m_pos[k] == frame_len(k) - 1) m_act[k] <= 1'b0;
            else m_pos[k] <= m_pos[k] + 1;
         end
      end
   end

   // Measurements of the DUT line used by the literal expectations.
   int         done_cnt [2], f_ticks [2], f_cycles [2], low_run [2], last_low [2];
   int         last_ticks [2], last_cycles [2], since_done [2], last_gap [2], cap_n [2];
   logic [9:0] cap [2], last_cap [2];
   logic       prev_busy [2], obs_tx [2], obs_busy [2];

   bit chk_en      = 1'b0;
   bit tick_rand   = 1'b0;
   int tick_period = 1;
   int tick_cnt    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      if (tick_rand) begin
         s_tick = ($urandom_range(0, 2) == 0);
      end else begin
         s_tick   = (tick_cnt == 0);
         tick_cnt = (tick_cnt + 1 >= tick_period) ? 0 : tick_cnt + 1;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         logic edone;
         edone = m_act[k] && s_tick && (m_pos[k] == frame_len(k) - 1);
         if (chk_en) begin
            chk($sformatf("tx%0d", k), 32'(tx_w[k]), 32'(exp_tx(k)));
            chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(m_act[k]));
            chk($sformatf("done%0d", k), 32'(done_w[k]), 32'(edone));
         end
         obs_tx[k]   = tx_w[k];
         obs_busy[k] = busy_w[k];
         since_done[k]++;
         if (busy_w[k] === 1'b1 && prev_busy[k] !== 1'b1) begin
            cap[k]      = '0;
            cap_n[k]    = 0;
            f_ticks[k]  = 0;
            f_cycles[k] = 0;
            last_gap[k] = since_done[k];
         end
         if (busy_w[k] === 1'b1) begin
            f_cycles[k]++;
            if (s_tick) begin
               if ((f_ticks[k] % 16) == 8 && cap_n[k] < 10) begin
                  cap[k][cap_n[k]] = tx_w[k];
                  cap_n[k]++;
               end
               f_ticks[k]++;
            end
         end
         if (tx_w[k] === 1'b0) begin
            low_run[k]++;
         end else if (low_run[k] > 0) begin
            last_low[k] = low_run[k];
            low_run[k]  = 0;
         end
         if (done_w[k] === 1'b1) begin
            done_cnt[k]++;
            last_ticks[k]  = f_ticks[k];
            last_cycles[k] = f_cycles[k];
            last_cap[k]    = cap[k];
            since_done[k]  = 0;
            $display("frame inst=%0d ticks=%0d cycles=%0d bits=%h t=%0t",
                     k, f_ticks[k], f_cycles[k], cap[k], $time);
         end
         prev_busy[k] = busy_w[k];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int k, input int budget);
      int c0;
      c0 = done_cnt[k];
      for (int i = 0; i < budget && done_cnt[k] == c0; i++) step();
      if (done_cnt[k] == c0) begin
         $display("FAIL timeout_done%0d got=none exp=pulse within %0d cycles", k, budget);
         $fatal(1, "timeout");
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy_w != 2'b00; i++) step();
      if (busy_w != 2'b00) begin
         $display("FAIL timeout_idle got=%b exp=00", busy_w);
         $fatal(1, "timeout");
      end
      repeat (4) step();
   endtask

   task automatic send(input logic [7:0] d);
      din      = d;
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
   endtask

   initial begin
      int d0, d1;
      rst      = 1'b1;
      s_tick   = 1'b0;
      tx_start = 1'b0;
      din      = '0;
      for (int k = 0; k < 2; k++) begin
         done_cnt[k] = 0;  f_ticks[k] = 0;    f_cycles[k] = 0;   low_run[k] = 0;
         last_low[k] = 0;  last_ticks[k] = 0; last_cycles[k] = 0;
         since_done[k] = -1000; last_gap[k] = -1; cap_n[k] = 0;
         cap[k] = '0; last_cap[k] = '0; prev_busy[k] = 1'b0;
      end

      // Reset, with a start request that must be ignored.
      tx_start = 1'b1;
      repeat (3) step();
      chk_en = 1'b1;
      tx_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_tx%0d", k), 32'(obs_tx[k]), 32'd1);
         chk($sformatf("rst_busy%0d", k), 32'(obs_busy[k]), 32'd0);
      end
      rst = 1'b0;
      repeat (5) step();

      // Basic frame, tick every cycle: start,1,0,1,0,0,1,0,1,stop.
      tick_period = 1;
      send(8'hA5);
      wait_done(0, 400);
      chk("basic_ticks0", last_ticks[0], 160);
      chk("basic_cycles0", last_cycles[0], 160);
      chk("basic_bits0", 32'(last_cap[0]), 32'h34A);
      wait_done(1, 400);
      chk("basic_ticks1", last_ticks[1], 176);
      chk("basic_bits1", 32'(last_cap[1]), 32'h34A);
      wait_idle(100);

      // Sparse tick every 27th cycle, start issued on a tick cycle.
      tick_period = 27;
      tick_cnt    = 0;
      send(8'h00);
      wait_done(0, 6000);
      chk("sparse_low0", last_low[0], 3888);
      chk("sparse_cycles0", last_cycles[0], 4320);
      chk("sparse_ticks0", last_ticks[0], 160);
      wait_done(1, 1000);
      chk("sparse_low1", last_low[1], 3888);
      chk("sparse_cycles1", last_cycles[1], 4752);
      chk("sparse_ticks1", last_ticks[1], 176);
      tick_period = 1;
      wait_idle(100);

      // Start request during DATA must not disturb the frame.
      send(8'h3C);
      repeat (40) step();
      din      = 8'hFF;
      tx_start = 1'b1;
      repeat (5) step();
      tx_start = 1'b0;
      din      = 8'h00;
      wait_done(0, 400);
      chk("ign_bits0", 32'(last_cap[0]), 32'h278);
      d0 = done_cnt[0];
      repeat (60) step();
      chk("ign_nodone0", done_cnt[0], d0);
      chk("ign_idle0", 32'(busy_w[0]), 32'd0);
      chk("ign_bits1", 32'(last_cap[1]), 32'h278);
      wait_idle(100);

      // Reset during bit 3, with a start request held through the reset cycle.
      send(8'h96);
      repeat (70) step();
      d0 = done_cnt[0];
      d1 = done_cnt[1];
      rst      = 1'b1;
      tx_start = 1'b1;
      din      = 8'h12;
      step();
      rst      = 1'b0;
      tx_start = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("midrst_tx%0d", k), 32'(obs_tx[k]), 32'd1);
         chk($sformatf("midrst_busy%0d", k), 32'(obs_busy[k]), 32'd0);
      end
      repeat (200) step();
      chk("midrst_nodone0", done_cnt[0], d0);
      chk("midrst_nodone1", done_cnt[1], d1);
      send(8'h55);
      wait_done(0, 400);
      chk("after_rst_bits0", 32'(last_cap[0]), 32'h2AA);
      wait_done(1, 400);
      chk("after_rst_bits1", 32'(last_cap[1]), 32'h2AA);
      wait_idle(100);

      // Back-to-back with start held high.
      din      = 8'h81;
      tx_start = 1'b1;
      wait_done(0, 400);
      chk("b2b_bits_a", 32'(last_cap[0]), 32'h302);
      din = 8'h7E;
      repeat (5) step();
      tx_start = 1'b0;
      chk("b2b_gap", last_gap[0], 2);
      wait_done(0, 400);
      chk("b2b_bits_b", 32'(last_cap[0]), 32'h2FC);
      chk("b2b_ticks", last_ticks[0], 160);
      wait_idle(400);

      // Random ticks, data, requests and occasional reset.
      tick_rand = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         tx_start = ($urandom_range(0, 19) == 0);
         din      = 8'($urandom);
         rst      = ($urandom_range(0, 499) == 0);
         step();
      end
      rst      = 1'b0;
      tx_start = 1'b0;
      wait_idle(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
